cci_mpf_shim_rd_throttle: RTL and testbench
===========================================

Name: cci_mpf_shim_rd_throttle

Overview:
- MPF shim between AFU-side and FIU-side MPF CCI interfaces.
- Tracks read lines in flight on channel 0 and throttles the AFU when the count nears a programmed ceiling.
- Registers c0 requests by one stage toward the FIU.
- Passes c1, c2 and all responses through unchanged.

Parameters:
- MAX_RD_LINES, 256: ceiling on outstanding read lines (cache lines, not requests).
- ALM_FULL_SLACK, 8: requests the AFU may still issue after almost-full asserts; reserve = 4*ALM_FULL_SLACK lines.
- CNT_WIDTH, $clog2(MAX_RD_LINES)+1: width of the in-flight counter.

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high; tied to fiu.reset at instantiation.
- fiu, interface, cci_mpf_if.to_fiu: toward platform.
- afu, interface, cci_mpf_if.to_afu: toward user logic.
- rd_lines_inflight, output, CNT_WIDTH: current in-flight line count.
- err_underflow, output, 1: sticky; a read response arrived with count 0.

Behaviour:
- afu.reset = fiu.reset (combinational).
- c1Tx, c2Tx, c1TxAlmFull, c0Rx and c1Rx pass through combinationally, with no state.
- c0Tx request path:
  - fiu.c0Tx is registered from afu.c0Tx; 1-cycle latency.
  - Valid is cleared on reset; header and data are don't-care while not valid.
- Line cost per read request: decoded from hdr cl_len.
  - 0 → 1 line, 1 → 2 lines, 3 → 4 lines.
  - Encoding 2 is treated as 4 lines (conservative).
  - Cost is applied on the cycle afu.c0Tx.valid is seen.
- Response decrement:
  - Each afu-bound c0Rx with rspValid and resp_type eRSP_RDLINE decrements the count by 1 (one line per response).
  - Other response types do not change the count.
- Simultaneous request and response in one cycle: next = cur + cost − 1, applied in a single update with no lost events.
- Underflow:
  - A read response with the count at 0 holds the count at 0 and sets err_underflow.
  - err_underflow clears only on reset.
- Overflow: the count saturates at 2^CNT_WIDTH−1, which is unreachable when the AFU honours almost-full.
- Almost-full:
  - afu.c0TxAlmFull is registered.
  - Next value = fiu.c0TxAlmFull OR (next_count + 4*ALM_FULL_SLACK ≥ MAX_RD_LINES).
  - It reflects requests from the same cycle one cycle later.
- Reset values:
  - count 0, err_underflow 0, fiu.c0Tx.valid 0.
  - afu.c0TxAlmFull is 1 during reset and for the cycle after it, then follows the rule above.
- Reset mid-operation: the count drops to 0 immediately. Late responses after reset deassertion will set err_underflow; this is by design and documented for integrators.
- No state machine beyond the counter; the block never drops or reorders requests.

Optional Feature:
- Macro: MPF_RD_THROTTLE_STATS_EN
- Defined:
  - Adds output rd_peak_inflight (CNT_WIDTH), the maximum count since reset.
  - Adds output rd_throttle_cycles (32 bits), counting cycles where the internal threshold alone held almost-full. This counter saturates at all-ones.
  - Both outputs reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cci_mpf_shim_pkg holds:
  - function cl_len_to_lines (2-bit cl_len → 3-bit line count);
  - localparam for the eRSP_RDLINE compare;
  - typedef t_rd_inflight_cnt.
- One natural sub-module: cci_mpf_prim_counter_updown.
  - Saturating up/down counter with simultaneous inc(k)/dec(1).
  - Underflow flag output.

Test Plan:
- Single cl_len=0 read, response 20 cycles later → count 0→1 on cycle after request, →0 after response; fiu.c0Tx.valid exactly 1 cycle after afu valid.
- MAX=256, SLACK=8: 56 back-to-back cl_len=3 reads, no responses → count reaches 224; afu.c0TxAlmFull asserts the cycle after the 56th request (224+32≥256).
- Same cycle: cl_len=1 request plus one RDLINE response with count 10 → count 11.
- RDLINE response with count 0 → count stays 0, err_underflow=1 and remains 1 until reset.
- fiu.c0TxAlmFull=1 with count 0 → afu.c0TxAlmFull=1 one cycle later; write responses on c0Rx leave the count unchanged.
- Reset asserted with count 100 → next cycle count 0, fiu.c0Tx.valid 0, afu.c0TxAlmFull 1; with MPF_RD_THROTTLE_STATS_EN, rd_peak_inflight reads 100 before reset and 0 after.

Source files
------------

// File: rtl/cci_mpf_shim_pkg.sv
// Shared CCI/MPF types and helpers for the MPF shims.
package cci_mpf_shim_pkg;

  localparam int unsigned CCI_DATA_WIDTH  = 512;
  localparam int unsigned CCI_ADDR_WIDTH  = 42;
  localparam int unsigned CCI_MDATA_WIDTH = 16;

  localparam int unsigned RD_MAX_LINES_DEFAULT = 256;
  localparam int unsigned RD_CNT_WIDTH_DEFAULT = $clog2(RD_MAX_LINES_DEFAULT) + 1;

  typedef logic [RD_CNT_WIDTH_DEFAULT-1:0] t_rd_inflight_cnt;

  typedef logic [3:0] t_resp_type;
  localparam t_resp_type eRSP_RDLINE = 4'h0;

  typedef enum logic [1:0] {
    eCL_LEN_1    = 2'b00,
    eCL_LEN_2    = 2'b01,
    eCL_LEN_RSVD = 2'b10,
    eCL_LEN_4    = 2'b11
  } t_cl_len;

  typedef struct packed {
    logic [1:0]                 cl_len;
    logic [CCI_ADDR_WIDTH-1:0]  addr;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_req_hdr;

  typedef struct packed {
    logic     valid;
    t_req_hdr hdr;
  } t_c0_tx;

  typedef struct packed {
    logic                      valid;
    t_req_hdr                  hdr;
    logic [CCI_DATA_WIDTH-1:0] data;
  } t_c1_tx;

  typedef struct packed {
    logic        mmioRdValid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_c2_tx;

  typedef struct packed {
    t_resp_type                 resp_type;
    logic [1:0]                 cl_num;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_rsp_hdr;

  typedef struct packed {
    logic                      rspValid;
    logic                      mmioRdValid;
    logic                      mmioWrValid;
    t_rsp_hdr                  hdr;
    logic [CCI_DATA_WIDTH-1:0] data;
  } t_c0_rx;

  typedef struct packed {
    logic     rspValid;
    t_rsp_hdr hdr;
  } t_c1_rx;

  // The reserved encoding is charged as a full 4-line request.
  function automatic logic [2:0] cl_len_to_lines(input logic [1:0] cl_len);
    logic [2:0] lines;
    case (cl_len)
      eCL_LEN_1: lines = 3'd1;
      eCL_LEN_2: lines = 3'd2;
      default:   lines = 3'd4;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// MPF CCI bundle; to_fiu faces the platform, to_afu faces user logic.
interface cci_mpf_if;
  import cci_mpf_shim_pkg::*;

  logic   reset;
  t_c0_tx c0Tx;
  t_c1_tx c1Tx;
  t_c2_tx c2Tx;
  logic   c0TxAlmFull;
  logic   c1TxAlmFull;
  t_c0_rx c0Rx;
  t_c1_rx c1Rx;

  modport to_fiu (
    input  reset, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
    output c0Tx, c1Tx, c2Tx
  );

  modport to_afu (
    output reset, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
    input  c0Tx, c1Tx, c2Tx
  );

endinterface

// File: rtl/cci_mpf_prim_counter_updown.sv
// Saturating up/down counter: add inc and subtract dec in one update,
// clamp at zero (sticky underflow flag) and at all-ones.
module cci_mpf_prim_counter_updown #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 dec,
  output logic [WIDTH-1:0]     value,
  output logic [WIDTH-1:0]     value_next,
  output logic                 underflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           uf_event;

  always_comb begin
    sum        = {1'b0, value} + (WIDTH+1)'(inc);
    diff       = sum - (WIDTH+1)'(dec);
    uf_event   = dec && (sum == '0);
    value_next = value;
    if (uf_event) begin
      value_next = '0;
    end else if (diff[WIDTH]) begin
      value_next = '1;
    end else begin
      value_next = diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= '0;
      underflow <= 1'b0;
    end else begin
      value <= value_next;
      if (uf_event) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cci_mpf_shim_rd_throttle.sv
// Read-line throttle shim: counts c0 read lines in flight and raises AFU
// almost-full near the ceiling. Optional stats: MPF_RD_THROTTLE_STATS_EN.
module cci_mpf_shim_rd_throttle
  import cci_mpf_shim_pkg::*;
#(
  parameter int unsigned MAX_RD_LINES   = 256,
  parameter int unsigned ALM_FULL_SLACK = 8,
  parameter int unsigned CNT_WIDTH      = $clog2(MAX_RD_LINES) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  cci_mpf_if.to_fiu            fiu,
  cci_mpf_if.to_afu            afu,
  output logic [CNT_WIDTH-1:0] rd_lines_inflight,
  output logic                 err_underflow
`ifdef MPF_RD_THROTTLE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] rd_peak_inflight,
  output logic [31:0]          rd_throttle_cycles
`endif
);

  t_c0_tx               c0tx_q;
  logic                 alm_full_q;
  logic [2:0]           req_lines;
  logic                 rsp_rdline;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 thresh_hit;

  assign afu.reset       = fiu.reset;
  assign fiu.c1Tx        = afu.c1Tx;
  assign fiu.c2Tx        = afu.c2Tx;
  assign afu.c1TxAlmFull = fiu.c1TxAlmFull;
  assign afu.c0Rx        = fiu.c0Rx;
  assign afu.c1Rx        = fiu.c1Rx;

  assign fiu.c0Tx        = c0tx_q;
  assign afu.c0TxAlmFull = alm_full_q;

  assign req_lines  = afu.c0Tx.valid ? cl_len_to_lines(afu.c0Tx.hdr.cl_len) : 3'd0;
  assign rsp_rdline = fiu.c0Rx.rspValid && (fiu.c0Rx.hdr.resp_type == eRSP_RDLINE);

  cci_mpf_prim_counter_updown #(
    .WIDTH     (CNT_WIDTH),
    .INC_WIDTH (3)
  ) rd_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc        (req_lines),
    .dec        (rsp_rdline),
    .value      (rd_lines_inflight),
    .value_next (cnt_next),
    .underflow  (err_underflow)
  );

  // Compare against the post-update count so this cycle's request is covered.
  assign thresh_hit = (32'(cnt_next) + 32'(4 * ALM_FULL_SLACK)) >= 32'(MAX_RD_LINES);

  always_ff @(posedge clk) begin
    c0tx_q <= afu.c0Tx;
    if (reset) begin
      c0tx_q.valid <= 1'b0;
      alm_full_q   <= 1'b1;
    end else begin
      alm_full_q <= fiu.c0TxAlmFull || thresh_hit;
    end
  end

`ifdef MPF_RD_THROTTLE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_peak_inflight   <= '0;
      rd_throttle_cycles <= '0;
    end else begin
      if (cnt_next > rd_peak_inflight) rd_peak_inflight <= cnt_next;
      if (thresh_hit && !fiu.c0TxAlmFull && (rd_throttle_cycles != '1)) begin
        rd_throttle_cycles <= rd_throttle_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_shim_rd_throttle.sv
// Self-checking bench for cci_mpf_shim_rd_throttle (MAX=256, SLACK=8).
module tb_cci_mpf_shim_rd_throttle;
  import cci_mpf_shim_pkg::*;

  localparam int MAX   = 256;
  localparam int SLACK = 8;
  localparam int CW    = 9;
  localparam int SAT   = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  cci_mpf_if fiu_if ();
  cci_mpf_if afu_if ();

  logic [CW-1:0] rd_lines_inflight;
  logic          err_underflow;
`ifdef MPF_RD_THROTTLE_STATS_EN
  logic [CW-1:0] rd_peak_inflight;
  logic [31:0]   rd_throttle_cycles;
`endif

  cci_mpf_shim_rd_throttle #(
    .MAX_RD_LINES   (MAX),
    .ALM_FULL_SLACK (SLACK)
  ) dut (
    .clk               (clk),
    .reset             (fiu_if.reset),
    .fiu               (fiu_if),
    .afu               (afu_if),
    .rd_lines_inflight (rd_lines_inflight),
    .err_underflow     (err_underflow)
`ifdef MPF_RD_THROTTLE_STATS_EN
    ,
    .rd_peak_inflight   (rd_peak_inflight),
    .rd_throttle_cycles (rd_throttle_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (plain integer arithmetic on line counts).
  int       m_cnt = 0;
  bit       m_err = 0;
  bit       m_almf = 1;
  bit       m_fvalid = 0;
  t_req_hdr m_fhdr;
  longint   m_peak = 0;
  longint   m_thr = 0;

  function automatic int lines_of(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1023:0] rnd1k();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Advance the model from the inputs currently driven, then clock the DUT.
  task automatic tick();
    int cost, rsp, n;
    bit thr;
    if (fiu_if.reset) begin
      m_cnt = 0; m_err = 0; m_almf = 1; m_fvalid = 0; m_peak = 0; m_thr = 0;
    end else begin
      cost = afu_if.c0Tx.valid ? lines_of(afu_if.c0Tx.hdr.cl_len) : 0;
      rsp  = (fiu_if.c0Rx.rspValid && fiu_if.c0Rx.hdr.resp_type == 4'h0) ? 1 : 0;
      n    = m_cnt + cost - rsp;
      if (n < 0) begin n = 0; m_err = 1; end
      if (n > SAT) n = SAT;
      m_cnt  = n;
      thr    = (n + 4 * SLACK >= MAX);
      m_almf = fiu_if.c0TxAlmFull || thr;
      if (thr && !fiu_if.c0TxAlmFull && m_thr < 64'hffff_ffff) m_thr++;
      if (n > m_peak) m_peak = n;
      m_fvalid = afu_if.c0Tx.valid;
    end
    m_fhdr = afu_if.c0Tx.hdr;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [1:0] l);
    afu_if.c0Tx.valid      = v;
    afu_if.c0Tx.hdr.cl_len = l;
    afu_if.c0Tx.hdr.addr   = 42'({$urandom(), $urandom()});
    afu_if.c0Tx.hdr.mdata  = 16'($urandom());
  endtask

  task automatic set_rsp(input bit v, input logic [3:0] t);
    fiu_if.c0Rx.rspValid      = v;
    fiu_if.c0Rx.mmioRdValid   = 1'b0;
    fiu_if.c0Rx.mmioWrValid   = 1'b0;
    fiu_if.c0Rx.hdr.resp_type = t;
    fiu_if.c0Rx.hdr.cl_num    = 2'd0;
    fiu_if.c0Rx.hdr.mdata     = 16'($urandom());
    fiu_if.c0Rx.data          = '0;
  endtask

  task automatic idle();
    set_req(1'b0, 2'd0);
    set_rsp(1'b0, 4'h0);
    fiu_if.c0TxAlmFull = 1'b0;
    fiu_if.c1TxAlmFull = 1'b0;
    fiu_if.c1Rx        = '0;
    afu_if.c1Tx        = '0;
    afu_if.c2Tx        = '0;
  endtask

  task automatic test_reset();
    fiu_if.reset = 1'b1;
    idle();
    repeat (3) tick();
    n_checks += 4;
    if (rd_lines_inflight !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", rd_lines_inflight); end
    if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    if (fiu_if.c0Tx.valid !== 1'b0) begin n_errors++; $display("FAIL reset_fiu_valid: got %b want 0", fiu_if.c0Tx.valid); end
    if (afu_if.c0TxAlmFull !== 1'b1) begin n_errors++; $display("FAIL reset_almf: got %b want 1", afu_if.c0TxAlmFull); end
    fiu_if.reset = 1'b0;
    #1;
    n_checks += 1;
    if (afu_if.c0TxAlmFull !== 1'b1) begin n_errors++; $display("FAIL reset_almf_after: got %b want 1", afu_if.c0TxAlmFull); end
    tick();
    n_checks += 2;
    if (afu_if.c0TxAlmFull !== 1'b0) begin n_errors++; $display("FAIL reset_almf_release: got %b want 0", afu_if.c0TxAlmFull); end
    if (rd_lines_inflight !== '0) begin n_errors++; $display("FAIL reset_count_after: got %0d want 0", rd_lines_inflight); end
  endtask

  task automatic test_single_read();
    t_req_hdr sent;
    set_req(1'b1, 2'd0);
    sent = afu_if.c0Tx.hdr;
    #1;
    n_checks += 1;
    if (fiu_if.c0Tx.valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b want 0", fiu_if.c0Tx.valid); end
    tick();
    set_req(1'b0, 2'd0);
    n_checks += 3;
    if (rd_lines_inflight !== 9'd1) begin n_errors++; $display("FAIL single_count_up: got %0d want 1", rd_lines_inflight); end
    if (fiu_if.c0Tx.valid !== 1'b1) begin n_errors++; $display("FAIL single_fiu_valid: got %b want 1", fiu_if.c0Tx.valid); end
    if (fiu_if.c0Tx.hdr !== sent) begin n_errors++; $display("FAIL single_fiu_hdr: got %h want %h", fiu_if.c0Tx.hdr, sent); end
    tick();
    n_checks += 2;
    if (fiu_if.c0Tx.valid !== 1'b0) begin n_errors++; $display("FAIL single_fiu_valid_drop: got %b want 0", fiu_if.c0Tx.valid); end
    if (rd_lines_inflight !== 9'd1) begin n_errors++; $display("FAIL single_count_hold: got %0d want 1", rd_lines_inflight); end
    repeat (18) tick();
    set_rsp(1'b1, eRSP_RDLINE);
    tick();
    set_rsp(1'b0, 4'h0);
    n_checks += 2;
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL single_count_down: got %0d want 0", rd_lines_inflight); end
    if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL single_err: got %b want 0", err_underflow); end
  endtask

  task automatic test_alm_full();
    for (int i = 1; i <= 56; i++) begin
      set_req(1'b1, 2'd3);
      tick();
      if (i == 55) begin
        n_checks += 2;
        if (rd_lines_inflight !== 9'd220) begin n_errors++; $display("FAIL almf_count55: got %0d want 220", rd_lines_inflight); end
        if (afu_if.c0TxAlmFull !== 1'b0) begin n_errors++; $display("FAIL almf_at55: got %b want 0", afu_if.c0TxAlmFull); end
      end
    end
    set_req(1'b0, 2'd0);
    n_checks += 2;
    if (rd_lines_inflight !== 9'd224) begin n_errors++; $display("FAIL almf_count56: got %0d want 224", rd_lines_inflight); end
    if (afu_if.c0TxAlmFull !== 1'b1) begin n_errors++; $display("FAIL almf_at56: got %b want 1", afu_if.c0TxAlmFull); end
    for (int i = 0; i < 224; i++) begin
      set_rsp(1'b1, eRSP_RDLINE);
      tick();
      if (i == 0) begin
        n_checks += 2;
        if (rd_lines_inflight !== 9'd223) begin n_errors++; $display("FAIL almf_drain_count: got %0d want 223", rd_lines_inflight); end
        if (afu_if.c0TxAlmFull !== 1'b0) begin n_errors++; $display("FAIL almf_drain_release: got %b want 0", afu_if.c0TxAlmFull); end
      end
    end
    set_rsp(1'b0, 4'h0);
    n_checks += 1;
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL almf_drained: got %0d want 0", rd_lines_inflight); end
  endtask

  task automatic test_simultaneous();
    repeat (10) begin set_req(1'b1, 2'd0); tick(); end
    n_checks += 1;
    if (rd_lines_inflight !== 9'd10) begin n_errors++; $display("FAIL simul_pre: got %0d want 10", rd_lines_inflight); end
    set_req(1'b1, 2'd1);
    set_rsp(1'b1, eRSP_RDLINE);
    tick();
    n_checks += 1;
    if (rd_lines_inflight !== 9'd11) begin n_errors++; $display("FAIL simul_count: got %0d want 11", rd_lines_inflight); end
    set_req(1'b0, 2'd0);
    repeat (11) tick();
    set_rsp(1'b0, 4'h0);
    n_checks += 1;
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL simul_drain: got %0d want 0", rd_lines_inflight); end
  endtask

  task automatic test_underflow();
    set_rsp(1'b1, eRSP_RDLINE);
    tick();
    set_rsp(1'b0, 4'h0);
    n_checks += 2;
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL uflow_count: got %0d want 0", rd_lines_inflight); end
    if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uflow_set: got %b want 1", err_underflow); end
    set_req(1'b1, 2'd1); tick();
    set_req(1'b0, 2'd0); set_rsp(1'b1, eRSP_RDLINE); repeat (2) tick();
    set_rsp(1'b0, 4'h0); repeat (3) tick();
    n_checks += 2;
    if (err_underflow !== 1'b1) begin n_errors++; $display("FAIL uflow_sticky: got %b want 1", err_underflow); end
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL uflow_count_after: got %0d want 0", rd_lines_inflight); end
    fiu_if.reset = 1'b1;
    tick();
    fiu_if.reset = 1'b0;
    n_checks += 1;
    if (err_underflow !== 1'b0) begin n_errors++; $display("FAIL uflow_clear: got %b want 0", err_underflow); end
    tick();
  endtask

  task automatic test_fiu_almfull();
    fiu_if.c0TxAlmFull = 1'b1;
    tick();
    n_checks += 2;
    if (afu_if.c0TxAlmFull !== 1'b1) begin n_errors++; $display("FAIL fiu_almf_prop: got %b want 1", afu_if.c0TxAlmFull); end
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL fiu_almf_count: got %0d want 0", rd_lines_inflight); end
    fiu_if.c0TxAlmFull = 1'b0;
    repeat (3) begin set_req(1'b1, 2'd0); tick(); end
    set_req(1'b0, 2'd0);
    n_checks += 1;
    if (afu_if.c0TxAlmFull !== 1'b0) begin n_errors++; $display("FAIL fiu_almf_release: got %b want 0", afu_if.c0TxAlmFull); end
    for (int i = 0; i < 5; i++) begin
      set_rsp(1'b1, (i % 2 == 0) ? 4'h1 : 4'h6);
      tick();
    end
    set_rsp(1'b0, 4'h0);
    n_checks += 1;
    if (rd_lines_inflight !== 9'd3) begin n_errors++; $display("FAIL wr_rsp_count: got %0d want 3", rd_lines_inflight); end
    set_rsp(1'b1, eRSP_RDLINE);
    repeat (3) tick();
    set_rsp(1'b0, 4'h0);
  endtask

  task automatic test_passthrough();
    t_c1_tx c1; t_c2_tx c2; t_c0_rx r0; t_c1_rx r1; logic af; logic [1023:0] r;
    for (int i = 0; i < 20; i++) begin
      r = rnd1k(); c1 = r[$bits(t_c1_tx)-1:0];
      r = rnd1k(); c2 = r[$bits(t_c2_tx)-1:0];
      r = rnd1k(); r0 = r[$bits(t_c0_rx)-1:0];
      r = rnd1k(); r1 = r[$bits(t_c1_rx)-1:0];
      af = 1'($urandom());
      afu_if.c1Tx = c1; afu_if.c2Tx = c2; fiu_if.c0Rx = r0; fiu_if.c1Rx = r1;
      fiu_if.c1TxAlmFull = af;
      fiu_if.reset = (i == 7);
      #1;
      n_checks += 6;
      if (fiu_if.c1Tx !== c1) begin n_errors++; $display("FAIL pass_c1Tx: got %h want %h", fiu_if.c1Tx.hdr, c1.hdr); end
      if (fiu_if.c2Tx !== c2) begin n_errors++; $display("FAIL pass_c2Tx: got %h want %h", fiu_if.c2Tx, c2); end
      if (afu_if.c0Rx !== r0) begin n_errors++; $display("FAIL pass_c0Rx: got %h want %h", afu_if.c0Rx.hdr, r0.hdr); end
      if (afu_if.c1Rx !== r1) begin n_errors++; $display("FAIL pass_c1Rx: got %h want %h", afu_if.c1Rx, r1); end
      if (afu_if.c1TxAlmFull !== af) begin n_errors++; $display("FAIL pass_c1almf: got %b want %b", afu_if.c1TxAlmFull, af); end
      if (afu_if.reset !== (i == 7)) begin n_errors++; $display("FAIL pass_reset: got %b want %b", afu_if.reset, (i == 7)); end
    end
    fiu_if.reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    repeat (25) begin set_req(1'b1, 2'd3); tick(); end
    n_checks += 1;
    if (rd_lines_inflight !== 9'd100) begin n_errors++; $display("FAIL mid_count_pre: got %0d want 100", rd_lines_inflight); end
`ifdef MPF_RD_THROTTLE_STATS_EN
    n_checks += 1;
    if (rd_peak_inflight !== 9'd100) begin n_errors++; $display("FAIL mid_peak_pre: got %0d want 100", rd_peak_inflight); end
`endif
    set_req(1'b1, 2'd0);
    fiu_if.reset = 1'b1;
    tick();
    n_checks += 3;
    if (rd_lines_inflight !== 9'd0) begin n_errors++; $display("FAIL mid_count_post: got %0d want 0", rd_lines_inflight); end
    if (fiu_if.c0Tx.valid !== 1'b0) begin n_errors++; $display("FAIL mid_fiu_valid: got %b want 0", fiu_if.c0Tx.valid); end
    if (afu_if.c0TxAlmFull !== 1'b1) begin n_errors++; $display("FAIL mid_almf: got %b want 1", afu_if.c0TxAlmFull); end
`ifdef MPF_RD_THROTTLE_STATS_EN
    n_checks += 2;
    if (rd_peak_inflight !== 9'd0) begin n_errors++; $display("FAIL mid_peak_post: got %0d want 0", rd_peak_inflight); end
    if (rd_throttle_cycles !== 32'd0) begin n_errors++; $display("FAIL mid_thr_post: got %0d want 0", rd_throttle_cycles); end
`endif
    fiu_if.reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_req(!m_almf && ($urandom_range(2) != 0), 2'($urandom_range(3)));
      if (m_cnt > 0 && $urandom_range(1) == 1) set_rsp(1'b1, eRSP_RDLINE);
      else if ($urandom_range(7) == 0) set_rsp(1'b1, ($urandom_range(1) == 0) ? 4'h1 : 4'h4);
      else set_rsp(1'b0, 4'h0);
      fiu_if.c0TxAlmFull = ($urandom_range(15) == 0);
      fiu_if.reset = ($urandom_range(499) == 0);
      tick();
      n_checks += 4;
      if (rd_lines_inflight !== t_rd_inflight_cnt'(m_cnt)) begin n_errors++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, rd_lines_inflight, m_cnt); end
      if (err_underflow !== m_err) begin n_errors++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, err_underflow, m_err); end
      if (afu_if.c0TxAlmFull !== m_almf) begin n_errors++; $display("FAIL rand_almf cyc %0d: got %b want %b", cyc, afu_if.c0TxAlmFull, m_almf); end
      if (fiu_if.c0Tx.valid !== m_fvalid) begin n_errors++; $display("FAIL rand_fiu_valid cyc %0d: got %b want %b", cyc, fiu_if.c0Tx.valid, m_fvalid); end
      if (m_fvalid) begin
        n_checks += 1;
        if (fiu_if.c0Tx.hdr !== m_fhdr) begin n_errors++; $display("FAIL rand_fiu_hdr cyc %0d: got %h want %h", cyc, fiu_if.c0Tx.hdr, m_fhdr); end
      end
`ifdef MPF_RD_THROTTLE_STATS_EN
      n_checks += 2;
      if (rd_peak_inflight !== t_rd_inflight_cnt'(m_peak)) begin n_errors++; $display("FAIL rand_peak cyc %0d: got %0d want %0d", cyc, rd_peak_inflight, m_peak); end
      if (rd_throttle_cycles !== 32'(m_thr)) begin n_errors++; $display("FAIL rand_thr cyc %0d: got %0d want %0d", cyc, rd_throttle_cycles, m_thr); end
`endif
    end
    fiu_if.reset = 1'b0;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    fiu_if.reset = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_alm_full();
    test_simultaneous();
    test_underflow();
    test_fiu_almfull();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
